// File: rtl/commit_trace_pkg.sv
// Shared record type and lane-compaction helper for the commit trace queue.
package commit_trace_pkg;

    localparam int CT_XLEN   = 64;
    localparam int MAX_LANES = 4;
    localparam int OFFS_W    = 3;

    typedef struct packed {
        logic               is_trap;
        logic [CT_XLEN-1:0] pc;
        logic [31:0]        insn;
        logic               wen;
        logic [4:0]         waddr;
        logic [CT_XLEN-1:0] wdata;
    } commit_rec_t;

    localparam int REC_W = $bits(commit_rec_t);

    typedef logic [MAX_LANES-1:0][OFFS_W-1:0] lane_offs_t;

    // Slot offset of each lane = number of valid lanes older than it.
    function automatic lane_offs_t compact_offsets(input logic [MAX_LANES-1:0] v);
        lane_offs_t        offs;
        logic [OFFS_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            offs[i] = acc;
            acc     = acc + OFFS_W'(v[i]);
        end
        return offs;
    endfunction

endpackage

// File: rtl/commit_trace_queue_if.sv
// Retire-side input bus and checker-side output bus of the commit trace queue.
interface commit_trace_queue_if #(
    parameter int COMMITS = 2,
    parameter int XLEN    = 64
);
    logic [COMMITS-1:0]      in_valid;
    logic [COMMITS*XLEN-1:0] in_pc;
    logic [COMMITS*32-1:0]   in_insn;
    logic [COMMITS-1:0]      in_wen;
    logic [COMMITS*5-1:0]    in_waddr;
    logic [COMMITS*XLEN-1:0] in_wdata;
    logic                    in_trap_valid;
    logic [XLEN-1:0]         in_trap_cause;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_is_trap;
    logic [XLEN-1:0]         out_pc;
    logic [31:0]             out_insn;
    logic                    out_wen;
    logic [4:0]              out_waddr;
    logic [XLEN-1:0]         out_wdata;

    modport master (
        output in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
               in_trap_valid, in_trap_cause, out_ready,
        input  out_valid, out_is_trap, out_pc, out_insn, out_wen, out_waddr, out_wdata
    );

    modport slave (
        input  in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
               in_trap_valid, in_trap_cause, out_ready,
        output out_valid, out_is_trap, out_pc, out_insn, out_wen, out_waddr, out_wdata
    );
endinterface

// File: rtl/commit_trace_ram.sv
// Record storage: NWP write ports (distinct addresses per cycle), one async read port.
module commit_trace_ram
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NWP   = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic [NWP-1:0]                we,
    input  logic [NWP-1:0][AW-1:0]        waddr,
    input  commit_rec_t [NWP-1:0]         wdata,
    input  logic [AW-1:0]                 raddr,
    output commit_rec_t                   rdata
);

    commit_rec_t mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int p = 0; p < NWP; p++) begin
            if (we[p]) mem[waddr[p]] <= wdata[p];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_queue.sv
// Compacts up to COMMITS retire records plus a trap per cycle into an ordered FIFO
// drained one record per handshake; cycles that do not fit are dropped whole.
module commit_trace_queue
    import commit_trace_pkg::*;
#(
    parameter int COMMITS      = 2,
    parameter int DEPTH        = 16,
    parameter int XLEN         = CT_XLEN,   // record layout is fixed at CT_XLEN
    parameter int AFULL_MARGIN = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    commit_trace_queue_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int CW  = $clog2(DEPTH+1);
    localparam int AW  = $clog2(DEPTH);
    localparam int NWP = COMMITS + 1;

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          afull_q, afull_d, ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;

    logic [MAX_LANES-1:0]    v_ext;
    lane_offs_t              offs;
    logic [CW-1:0]           lane_cnt, n_in, n_acc, free;
    logic                    accept, deq;
    logic [NWP-1:0]          we;
    logic [NWP-1:0][AW-1:0]  waddr;
    commit_rec_t [NWP-1:0]   wrec;
    commit_rec_t             head;

    always_comb begin
        v_ext                = '0;
        v_ext[COMMITS-1:0]   = bus.in_valid;
        offs                 = compact_offsets(v_ext);
        lane_cnt             = '0;
        for (int i = 0; i < COMMITS; i++) lane_cnt = lane_cnt + CW'(bus.in_valid[i]);
        n_in   = lane_cnt + CW'(bus.in_trap_valid);
        // Free space ignores this cycle's dequeue so admission never depends on out_ready.
        free   = CW'(DEPTH) - count_q;
        accept = (n_in <= free);
        deq    = (count_q != '0) && bus.out_ready;

        for (int i = 0; i < COMMITS; i++) begin
            we[i]            = accept && bus.in_valid[i];
            waddr[i]         = wptr_q + AW'(offs[i]);
            wrec[i].is_trap  = 1'b0;
            wrec[i].pc       = bus.in_pc[i*XLEN +: XLEN];
            wrec[i].insn     = bus.in_insn[i*32 +: 32];
            wrec[i].waddr    = bus.in_waddr[i*5 +: 5];
            wrec[i].wen      = bus.in_wen[i] && (bus.in_waddr[i*5 +: 5] != 5'd0);
            wrec[i].wdata    = bus.in_wdata[i*XLEN +: XLEN];
        end
        we[COMMITS]    = accept && bus.in_trap_valid;
        waddr[COMMITS] = wptr_q + AW'(lane_cnt);
        wrec[COMMITS]  = '{is_trap: 1'b1, pc: '0, insn: '0, wen: 1'b0, waddr: '0,
                           wdata: bus.in_trap_cause};

        n_acc   = accept ? n_in : '0;
        wptr_d  = wptr_q + AW'(n_acc);
        rptr_d  = rptr_q + AW'(deq);
        count_d = count_q + n_acc - CW'(deq);
        afull_d = (CW'(DEPTH) - count_d) <= CW'(AFULL_MARGIN);
        ovf_d   = ovf_q || !accept;
        drop_d  = (!accept && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    commit_trace_ram #(.DEPTH(DEPTH), .NWP(NWP), .AW(AW)) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wrec),
        .raddr (rptr_q),
        .rdata (head)
    );

    // Storage is not reset, so the head is masked while the queue is empty.
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_is_trap = bus.out_valid ? head.is_trap : 1'b0;
    assign bus.out_pc      = bus.out_valid ? head.pc      : '0;
    assign bus.out_insn    = bus.out_valid ? head.insn    : '0;
    assign bus.out_wen     = bus.out_valid ? head.wen     : 1'b0;
    assign bus.out_waddr   = bus.out_valid ? head.waddr   : '0;
    assign bus.out_wdata   = bus.out_valid ? head.wdata   : '0;

    assign count       = count_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Randomized bench for commit_trace_queue against a queue-based reference model.
module tb_commit_trace_queue;
    import commit_trace_pkg::*;

    localparam int COMMITS = 2;
    localparam int DEPTH   = 16;
    localparam int XLEN    = 64;
    localparam int MARGIN  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  count;
    logic        almost_full, overflow;
    logic [15:0] drop_count;

    commit_trace_queue_if #(.COMMITS(COMMITS), .XLEN(XLEN)) bus ();

    commit_trace_queue #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN), .AFULL_MARGIN(MARGIN)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    commit_rec_t mq[$];
    logic        m_ovf;
    int          m_drop;
    logic [63:0] pcn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of records, whole-cycle admit/drop against pre-cycle free space.
    task automatic model_update();
        int n, free;
        bit deq;
        commit_rec_t r;
        if (reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            return;
        end
        n = int'(bus.in_trap_valid);
        for (int i = 0; i < COMMITS; i++) n += int'(bus.in_valid[i]);
        free = DEPTH - mq.size();
        deq  = (mq.size() != 0) && bus.out_ready;
        if (deq) void'(mq.pop_front());
        if (n <= free) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (bus.in_valid[i]) begin
                    r.is_trap = 1'b0;
                    r.pc      = bus.in_pc[i*XLEN +: XLEN];
                    r.insn    = bus.in_insn[i*32 +: 32];
                    r.waddr   = bus.in_waddr[i*5 +: 5];
                    r.wen     = bus.in_wen[i] && (r.waddr != 0);
                    r.wdata   = bus.in_wdata[i*XLEN +: XLEN];
                    mq.push_back(r);
                end
            end
            if (bus.in_trap_valid) begin
                r = '0;
                r.is_trap = 1'b1;
                r.wdata   = bus.in_trap_cause;
                mq.push_back(r);
            end
        end else begin
            m_ovf = 1'b1;
            if (m_drop < 16'hFFFF) m_drop++;
        end
    endtask

    task automatic compare_all();
        commit_rec_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid",   64'(bus.out_valid),   64'(mq.size() != 0));
        chk("count",       64'(count),           64'(mq.size()));
        chk("almost_full", 64'(almost_full),     64'((DEPTH - mq.size()) <= MARGIN));
        chk("overflow",    64'(overflow),        64'(m_ovf));
        chk("drop_count",  64'(drop_count),      64'(m_drop));
        chk("out_is_trap", 64'(bus.out_is_trap), 64'(h.is_trap));
        chk("out_pc",      bus.out_pc,           h.pc);
        chk("out_insn",    64'(bus.out_insn),    64'(h.insn));
        chk("out_wen",     64'(bus.out_wen),     64'(h.wen));
        chk("out_waddr",   64'(bus.out_waddr),   64'(h.waddr));
        chk("out_wdata",   bus.out_wdata,        h.wdata);
    endtask

    // Inputs are driven at negedge; the model steps on posedge; outputs compared at next negedge.
    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle();
        bus.in_valid      = '0;
        bus.in_pc         = '0;
        bus.in_insn       = '0;
        bus.in_wen        = '0;
        bus.in_waddr      = '0;
        bus.in_wdata      = '0;
        bus.in_trap_valid = 1'b0;
        bus.in_trap_cause = '0;
    endtask

    task automatic set_lane(input int i, input logic [63:0] pc);
        bus.in_valid[i]              = 1'b1;
        bus.in_pc[i*XLEN +: XLEN]    = pc;
        bus.in_insn[i*32 +: 32]      = 32'h0000_0013 ^ pc[31:0];
        bus.in_wen[i]                = 1'b1;
        bus.in_waddr[i*5 +: 5]       = 5'(i + 1);
        bus.in_wdata[i*XLEN +: XLEN] = ~pc;
    endtask

    task automatic rand_lanes();
        idle();
        for (int i = 0; i < COMMITS; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                bus.in_valid[i]              = 1'b1;
                bus.in_pc[i*XLEN +: XLEN]    = pcn;
                bus.in_insn[i*32 +: 32]      = $urandom;
                bus.in_wen[i]                = 1'($urandom);
                bus.in_waddr[i*5 +: 5]       = 5'($urandom_range(0, 31));
                bus.in_wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
                pcn += 4;
            end
        end
        if ($urandom_range(0, 7) == 0) begin
            bus.in_trap_valid = 1'b1;
            bus.in_trap_cause = 64'($urandom_range(0, 15));
        end
    endtask

    initial begin
        m_ovf = 1'b0; m_drop = 0; pcn = 64'h2000;
        idle();
        bus.out_ready = 1'b0;
        reset = 1'b1;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count",     64'(count),         64'd0);
        chk("rst_overflow",  64'(overflow),      64'd0);
        chk("rst_drops",     64'(drop_count),    64'd0);

        // Dual retire
        bus.out_ready = 1'b1;
        set_lane(0, 64'h8000_0000);
        set_lane(1, 64'h8000_0004);
        tick();
        idle();
        chk("dual_pc0", bus.out_pc, 64'h8000_0000);
        tick();
        chk("dual_pc1", bus.out_pc, 64'h8000_0004);
        tick();
        chk("dual_empty", 64'(count), 64'd0);

        // Sparse lane followed by trap
        set_lane(1, 64'h8000_0010);
        bus.in_trap_valid = 1'b1;
        bus.in_trap_cause = 64'h2;
        tick();
        idle();
        chk("sparse_pc",   bus.out_pc,             64'h8000_0010);
        chk("sparse_trap", 64'(bus.out_is_trap),   64'd0);
        tick();
        chk("trap_flag",   64'(bus.out_is_trap),   64'd1);
        chk("trap_cause",  bus.out_wdata,          64'h2);
        chk("trap_pc",     bus.out_pc,             64'd0);
        tick();

        // Fill and overflow
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_lane(0, 64'h3000 + 64'(c * 8));
            set_lane(1, 64'h3004 + 64'(c * 8));
            tick();
        end
        chk("fill_count", 64'(count),       64'd16);
        chk("fill_afull", 64'(almost_full), 64'd1);
        idle();
        set_lane(0, 64'h4000);
        tick();
        idle();
        chk("ovf_count", 64'(count),      64'd16);
        chk("ovf_flag",  64'(overflow),   64'd1);
        chk("ovf_drops", 64'(drop_count), 64'd1);
        bus.out_ready = 1'b1;
        repeat (17) tick();

        // Wrap-around stream with throttled checker
        for (int c = 0; c < 20; c++) begin
            idle();
            set_lane(0, 64'h1000 + 64'(c * 8));
            set_lane(1, 64'h1004 + 64'(c * 8));
            bus.out_ready = ((c / 2) % 2) == 0;
            tick();
        end
        idle();
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("wrap_drained", 64'(count), 64'd0);

        // Reset mid-stream
        bus.out_ready = 1'b0;
        set_lane(0, 64'h5000); set_lane(1, 64'h5004); tick();
        set_lane(0, 64'h5008); set_lane(1, 64'h500c); tick();
        idle(); set_lane(0, 64'h5010); tick();
        idle();
        chk("mid_count5", 64'(count), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_count0", 64'(count),         64'd0);
        chk("mid_valid0", 64'(bus.out_valid), 64'd0);
        set_lane(0, 64'hABC0);
        tick();
        idle();
        chk("mid_first", bus.out_pc,      64'hABC0);
        chk("mid_ovf",   64'(overflow),   64'd0);

        // Random traffic: heavy back-pressure first, then light
        for (int c = 0; c < 600; c++) begin
            rand_lanes();
            bus.out_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        idle();
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("final_drained", 64'(count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/commit_trace_queue.md
Name: commit_trace_queue

Overview:
- Sits between the core's retire ports and the difftest checker.
- Each cycle it captures up to COMMITS retired-instruction records plus one optional trap record, compacts them in program order, and buffers them in a circular FIFO.
- It drains exactly one record per accepted handshake, so the checker consumes a single ordered stream regardless of core width.
- The core cannot be stalled, so overflow is detected, the offending cycle is dropped atomically, and the condition is flagged sticky.

Parameters:
COMMITS, 2, retire lanes per cycle (1..4)
DEPTH, 16, FIFO entries; power of two, >= 2*(COMMITS+1)
XLEN, 64, pc/wdata/cause width
AFULL_MARGIN, 4, almost_full asserts when free slots <= this value

Ports:
clock  in  1  sole clock, all state on posedge
reset  in  1  synchronous, active-high
in_valid  in  COMMITS  per-lane retire valid; lane 0 is oldest
in_pc  in  COMMITS*XLEN  lane i at bits [i*XLEN +: XLEN]
in_insn  in  COMMITS*32  raw instruction per lane
in_wen  in  COMMITS  lane writes an integer register
in_waddr  in  COMMITS*5  destination register index
in_wdata  in  COMMITS*XLEN  writeback value
in_trap_valid  in  1  trap taken this cycle; it is younger than all valid lanes
in_trap_cause  in  XLEN  mcause-format cause
out_valid  out  1  head record available
out_ready  in  1  checker accepts head
out_is_trap  out  1  head is a trap record
out_pc  out  XLEN  head pc; 0 for trap records
out_insn  out  32  head instruction; 0 for trap records
out_wen  out  1  head register write enable; 0 for trap records
out_waddr  out  5  head register index
out_wdata  out  XLEN  head write data or trap cause
count  out  clog2(DEPTH+1)  occupied entries
almost_full  out  1  free slots <= AFULL_MARGIN
overflow  out  1  sticky; set when any cycle was dropped
drop_count  out  16  cycles dropped; saturates at 0xFFFF

Behaviour:
- Reset values: out_valid=0, count=0, almost_full=0, overflow=0, drop_count=0. Read and write pointers are set to 0. The head data outputs read 0.
- Reset mid-operation flushes all entries; no record is emitted in that cycle.
- Incoming record count N is popcount(in_valid) + in_trap_valid, ranging 0..COMMITS+1.
- Compaction: valid lanes are written to consecutive slots from wptr in ascending lane order; invalid lanes are skipped (e.g. in_valid=2'b10 writes one entry). The trap record follows the last valid lane.
- Lane fields are stored unchanged, with one rule: waddr==0 with wen=1 is stored with wen forced to 0.
- Admission rule: free is DEPTH-count, sampled at cycle start. This deliberately excludes the same-cycle dequeue.
  - If N <= free, all N records are written and wptr advances by N, modulo DEPTH.
  - If N > free, none are written, overflow is set, and drop_count increments. The cycle is dropped atomically; no partial enqueue.
- Dequeue: when out_valid && out_ready at posedge, rptr advances by 1.
- The head outputs are a combinational read of entry[rptr]; out_valid = (count != 0).
- New records become visible on the cycle after their write, giving a latency of 1.
- Simultaneous enqueue and dequeue: count_next = count + N_accepted - deq. Pointers wrap at DEPTH with no gap.
- Holding out_ready low holds all head outputs stable.
- almost_full is registered from count_next.
- overflow and drop_count clear only on reset.

Decomposition:
- Package commit_trace_pkg holds:
  - the commit_rec_t struct {is_trap, pc, insn, wen, waddr, wdata};
  - the REC_W constant;
  - a lane-compaction function returning per-lane slot offsets.
- One sub-module, commit_trace_ram: a DEPTH x REC_W storage array with up to COMMITS+1 write ports and one asynchronous read port.
- Pointers, counters and admission logic stay in the top module.

Test Plan:
- Reset sequence: hold reset 3 cycles, then release → out_valid=0, count=0, overflow=0, drop_count=0.
- Dual retire: in_valid=2'b11, pc0=0x80000000, pc1=0x80000004, out_ready=1 → next cycle emits 0x80000000, then 0x80000004 on the following cycle, count back to 0.
- Sparse lane plus trap: in_valid=2'b10, pc1=0x80000010, in_trap_valid=1, in_trap_cause=0x2 → two records: pc 0x80000010, then is_trap=1 with wdata=0x2.
- Fill and overflow: out_ready=0, drive 8 cycles of 2 commits (count=16); a 9th cycle with 1 commit → nothing written, overflow=1, drop_count=1, count stays 16, almost_full=1.
- Wrap-around: with out_ready=1, stream 40 sequential pcs (0x1000, step 4) at 2 per cycle, toggling out_ready every other cycle → output pcs strictly sequential across pointer wrap, and either no drops occur or each dropped cycle is reflected in drop_count.
- Reset mid-stream: count=5, assert reset 1 cycle → count=0, out_valid=0 next cycle, first post-reset record is the first post-reset commit.
